cpu_sequencer: RTL

//   Multi-cycle control FSM for the 9-bit-instruction core. Sequences fetch,

---
 rtl/cpu_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the 9-bit core.
// Owns halt/fault, the memory wait timeout, and the saturating retire and busy-cycle counters.
module cpu_sequencer #(
    parameter int cnt_width   = 16,
    parameter int mem_timeout = 15
) (
    input  logic                 clk,
    input  logic                 start,
    input  logic                 is_halt,
    input  logic                 is_mem,
    input  logic                 is_branch,
    input  logic                 taken,
    input  logic                 dec_wr,
    input  logic                 mem_ack,
    output logic                 ir_load,
    output logic                 rf_we,
    output logic                 mem_req,
    output logic                 pc_en,
    output logic                 pc_sel_tgt,
    output logic                 halt,
    output logic                 fault,
    output logic                 busy,
    output logic [2:0]           state_dbg,
    output logic [cnt_width-1:0] instr_count,
    output logic [cnt_width-1:0] cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALTED = 3'd6
    } state_t;

    localparam int                WAIT_W     = $clog2(mem_timeout + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(mem_timeout);

    state_t              state;
    state_t              state_nxt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_cnt_nxt;
    logic [WAIT_W-1:0]   wait_inc;
    logic                retire;
    logic                timeout;
    logic                in_flight;
    logic                fault_q;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [cnt_width-1:0] sat_inc(input logic [cnt_width-1:0] v);
        return (&v) ? v : v + cnt_width'(1);
    endfunction

    assign wait_inc  = wait_cnt + WAIT_W'(1);
    assign in_flight = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC) ||
                       (state == S_MEM)   || (state == S_WB);

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        retire       = 1'b0;
        timeout      = 1'b0;
        case (state)
            S_IDLE:   state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                if (is_halt) begin
                    state_nxt = S_HALTED;
                    retire    = 1'b1;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_mem) begin
                    state_nxt    = S_MEM;
                    wait_cnt_nxt = '0;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                // An ack in the timeout cycle still completes the access.
                if (mem_ack) begin
                    state_nxt = S_WB;
                end else begin
                    wait_cnt_nxt = wait_inc;
                    if (wait_inc == WAIT_LIMIT) begin
                        state_nxt = S_HALTED;
                        timeout   = 1'b1;
                    end
                end
            end
            S_WB: begin
                state_nxt = S_FETCH;
                retire    = 1'b1;
            end
            S_HALTED: state_nxt = S_HALTED;
            default:  state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (start) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            fault_q     <= 1'b0;
            instr_count <= '0;
            cycle_count <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (timeout) begin
                fault_q <= 1'b1;
            end
            if (retire) begin
                instr_count <= sat_inc(instr_count);
            end
            if (in_flight) begin
                cycle_count <= sat_inc(cycle_count);
            end
        end
    end

    // Strobes are decoded from the state register; only rf_we and pc_sel_tgt see inputs.
    assign ir_load    = (state == S_FETCH);
    assign mem_req    = (state == S_MEM);
    assign pc_en      = (state == S_WB);
    assign rf_we      = (state == S_WB) && dec_wr;
    assign pc_sel_tgt = (state == S_WB) && is_branch && taken;
    assign halt       = (state == S_HALTED);
    assign fault      = fault_q;
    assign busy       = in_flight;
    assign state_dbg  = state;

endmodule
